// File: rtl/house_selector_if.sv
// rtl/house_selector_if.sv - button inputs and house-select outputs of house_selector
interface house_selector_if;
  logic [3:0] i_key_n;
  logic       i_sort_n;
  logic       o_gryffindor;
  logic       o_slytherin;
  logic       o_hufflepuff;
  logic       o_ravenclaw;
  logic       o_busy;

  modport master (
    output i_key_n, i_sort_n,
    input  o_gryffindor, o_slytherin, o_hufflepuff, o_ravenclaw, o_busy
  );

  modport slave (
    input  i_key_n, i_sort_n,
    output o_gryffindor, o_slytherin, o_hufflepuff, o_ravenclaw, o_busy
  );
endinterface

// File: rtl/house_selector.sv
// rtl/house_selector.sv - debounced one-hot house select; HOUSE_SHUFFLE_EN adds the sorting-hat shuffle
module house_selector #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SHUFFLE_STEP    = 2500000,
  parameter int SHUFFLE_STEPS   = 16
) (
  input  logic            clk,
  input  logic            i_rst,
  house_selector_if.slave bus
);

`ifdef HOUSE_SHUFFLE_EN
  localparam int NIN = 5;
`else
  localparam int NIN = 4;
`endif
  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] level;
  logic [NIN-1:0] level_d;
  logic [NIN-1:0] press;
  logic [DBW-1:0] cnt [NIN];
  logic [3:0]     house;
  logic [3:0]     house_evt;

`ifdef HOUSE_SHUFFLE_EN
  assign raw = {bus.i_sort_n, bus.i_key_n};
`else
  logic unused_sort;
  assign unused_sort = bus.i_sort_n;
  assign raw         = bus.i_key_n;
`endif

  // Debounced levels idle high (released); a press is a debounced fall.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      sync1   <= '1;
      sync2   <= '1;
      level   <= '1;
      level_d <= '1;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press     = level_d & ~level;
  assign house_evt = press[3:0];

  function automatic logic [3:0] pick(input logic [3:0] evt);
    if (evt[3])      return 4'b1000;
    else if (evt[2]) return 4'b0100;
    else if (evt[1]) return 4'b0010;
    else             return 4'b0001;
  endfunction

  assign bus.o_gryffindor = house[3];
  assign bus.o_slytherin  = house[2];
  assign bus.o_hufflepuff = house[1];
  assign bus.o_ravenclaw  = house[0];

`ifdef HOUSE_SHUFFLE_EN
  localparam int TW = (SHUFFLE_STEP > 2) ? $clog2(SHUFFLE_STEP) : 1;
  localparam int SW = $clog2(SHUFFLE_STEPS + 4);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SHUFFLE_STEP - 1);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_SHUFFLE = 1'b1;

  logic [0:0]    state;
  logic [15:0]   lfsr;
  logic [TW-1:0] timer;
  logic [SW-1:0] steps;
  logic          busy;
  logic          sort_evt;

  assign sort_evt   = press[4];
  assign bus.o_busy = busy;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      lfsr  <= 16'hACE1;
      timer <= '0;
      steps <= '0;
      busy  <= 1'b0;
      house <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (state == ST_IDLE) begin
        if (sort_evt) begin
          state <= ST_SHUFFLE;
          busy  <= 1'b1;
          house <= 4'b1000;
          steps <= SW'(SHUFFLE_STEPS) + SW'(lfsr[1:0]);
          timer <= '0;
        end else if (|house_evt) begin
          house <= pick(house_evt);
        end
      end else begin
        // Presses arriving here are dropped, not queued.
        if (timer == TIMER_LAST) begin
          timer <= '0;
          house <= {house[0], house[3:1]};
          steps <= steps - 1'b1;
          if (steps == SW'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end
`else
  assign bus.o_busy = 1'b0;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      house <= '0;
    end else if (|house_evt) begin
      house <= pick(house_evt);
    end
  end
`endif

endmodule

// File: tb/tb_house_selector.sv
// tb/tb_house_selector.sv - randomized self-checking bench for house_selector
module tb_house_selector;
  localparam int DEB   = 4;
  localparam int STEP  = 8;
  localparam int STEPS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  house_selector_if bus();

  house_selector #(
    .DEBOUNCE_CYCLES(DEB),
    .SHUFFLE_STEP(STEP),
    .SHUFFLE_STEPS(STEPS)
  ) dut (
    .clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] outs;
  assign outs = {bus.o_gryffindor, bus.o_slytherin, bus.o_hufflepuff, bus.o_ravenclaw};

  logic [3:0] exp_house;

  // Reference LFSR, x^16+x^14+x^13+x^11+1, stepped once per clock; prev holds the value
  // seen by the design during the cycle ending at the most recent edge.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] highest(input logic [3:0] mask);
    for (int b = 3; b >= 0; b--) if (mask[b]) return 4'(1 << b);
    return 4'b0000;
  endfunction

`ifdef HOUSE_SHUFFLE_EN
  task automatic run_shuffle(input bit press_keys);
    int waited;
    int n;
    bus.i_sort_n = 1'b0;
    waited = 0;
    while (!bus.o_busy && waited < 20) begin
      tick(1);
      waited++;
    end
    check("shuffle_start_busy", bus.o_busy, 1'b1);
    if (!bus.o_busy) begin
      bus.i_sort_n = 1'b1;
      tick(10);
      return;
    end
    check("shuffle_start_latency", waited, DEB + 3);
    check("shuffle_start_house", outs, 4'b1000);
    n = STEPS + int'(m_prev[1:0]);
    for (int k = 1; k <= n; k++) begin
      if (k == 2) bus.i_sort_n = 1'b1;
      if (press_keys && k == 3) bus.i_key_n = 4'($urandom_range(0, 14));
      if (press_keys && k == 6) bus.i_key_n = 4'hF;
      tick(STEP);
      check("shuffle_rotate", outs, 4'b1000 >> (k % 4));
      check("shuffle_busy", bus.o_busy, (k < n) ? 1'b1 : 1'b0);
    end
    exp_house = 4'b1000 >> (n % 4);
    tick(20);
    check("shuffle_final_hold", outs, exp_house);
    check("shuffle_idle_busy", bus.o_busy, 1'b0);
  endtask
`endif

  initial begin
    logic [3:0] mask;
    bus.i_key_n  = 4'hF;
    bus.i_sort_n = 1'b1;
    exp_house    = 4'b0000;
    tick(3);
    check("reset_outs", outs, 4'b0000);
    check("reset_busy", bus.o_busy, 1'b0);

    // Direct select: Slytherin held from the cycle reset drops.
    rst         = 1'b0;
    bus.i_key_n = 4'b1011;
    for (int e = 1; e <= DEB + 2; e++) begin
      tick(1);
      check("latency_hold", outs, 4'b0000);
    end
    tick(1);
    check("latency_edge", outs, 4'b0100);
    bus.i_key_n = 4'hF;
    tick(12);
    check("release_hold", outs, 4'b0100);

    // Bounce on Ravenclaw shorter than the debounce window.
    for (int r = 0; r < 10; r++) begin
      bus.i_key_n[0] = 1'b0;
      tick(DEB - 1);
      bus.i_key_n[0] = 1'b1;
      tick(1);
    end
    tick(8);
    check("bounce_reject", outs, 4'b0100);
    bus.i_key_n[0] = 1'b0;
    tick(DEB + 2);
    check("bounce_settle_hold", outs, 4'b0100);
    tick(1);
    check("bounce_settle_edge", outs, 4'b0001);
    bus.i_key_n = 4'hF;
    tick(10);

    // All four at once: Gryffindor wins.
    bus.i_key_n = 4'b0000;
    tick(10);
    check("simultaneous", outs, 4'b1000);
    exp_house   = 4'b1000;
    bus.i_key_n = 4'hF;
    tick(10);

    // Random presses and random short glitches.
    for (int it = 0; it < 16; it++) begin
      mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        bus.i_key_n = ~mask;
        tick($urandom_range(1, DEB - 1));
        bus.i_key_n = 4'hF;
        tick(10);
        check("rand_glitch", outs, exp_house);
      end else begin
        bus.i_key_n = ~mask;
        tick(DEB + 4);
        if (mask != 4'b0000) exp_house = highest(mask);
        check("rand_press", outs, exp_house);
        bus.i_key_n = 4'hF;
        tick(DEB + 4);
        check("rand_release", outs, exp_house);
      end
    end

`ifdef HOUSE_SHUFFLE_EN
    for (int s = 0; s < 3; s++) begin
      tick($urandom_range(0, 7));
      run_shuffle(s != 0);
    end

    // Reset in the middle of a shuffle.
    bus.i_sort_n = 1'b0;
    tick(DEB + 3 + 20);
    check("pre_abort_busy", bus.o_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_outs", outs, 4'b0000);
    check("abort_busy", bus.o_busy, 1'b0);
    bus.i_sort_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    check("abort_hold_zero", outs, 4'b0000);
    bus.i_key_n = 4'b1101;
    tick(DEB + 4);
    check("abort_then_select", outs, 4'b0010);
    bus.i_key_n = 4'hF;
    tick(10);
`else
    // Without the shuffle feature the sort button does nothing.
    bus.i_sort_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(5);
      check("sort_ignored_busy", bus.o_busy, 1'b0);
    end
    check("sort_ignored_outs", outs, exp_house);
    bus.i_sort_n = 1'b1;
    tick(10);
    check("sort_release_outs", outs, exp_house);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
